i2c_apb_arbiter: RTL and testbench

//  Shares the single APB register port of the CoreI2C instance among N requesters
//  (slave-handler FSM, master-transaction sequencer, housekeeping/config logic).

---
 rtl/i2c_apb_pkg.sv | 18 +
 rtl/i2c_apb_arbiter_rr_arbiter.sv | 31 +++
 rtl/i2c_apb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_i2c_apb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the CoreI2C APB access path:
// register offsets and the APB sequencing FSM states.
package i2c_apb_pkg;

    localparam logic [8:0] REG_CTRL  = 9'h000;
    localparam logic [8:0] REG_STAT  = 9'h004;
    localparam logic [8:0] REG_DATA  = 9'h008;
    localparam logic [8:0] REG_ADDR0 = 9'h00C;
    localparam logic [8:0] REG_SMB   = 9'h010;
    localparam logic [8:0] REG_ADDR1 = 9'h01C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/i2c_apb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request found
// when scanning upward from ptr_i, wrapping at N_REQ.
module rr_arbiter
    import i2c_apb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [2:0]       win_o,
    output logic             valid_o
);

    always_comb begin
        logic [N_REQ-1:0] sh;
        int unsigned      j;
        win_o   = '0;
        valid_o = 1'b0;
        sh      = '0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j  = (int'(ptr_i) + i) % N_REQ;
            sh = req_i >> j;
            if (!valid_o && sh[0]) begin
                valid_o = 1'b1;
                win_o   = 3'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_apb_arbiter.sv
// Round-robin sharing of the CoreI2C APB port among N_REQ requesters.
// Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN.
module i2c_apb_arbiter
    import i2c_apb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*9-1:0] req_addr,
    input  logic [N_REQ*8-1:0] req_wdata,
    input  logic [N_REQ-1:0]   req_write,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic [2:0]         gnt_id,
    output logic [8:0]         PADDR,
    output logic [7:0]         PWDATA,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    input  logic [7:0]         PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    apb_state_e       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [8:0]       paddr_q, paddr_d;
    logic [7:0]       pwdata_q, pwdata_d;
    logic             pwrite_q, pwrite_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0]       cnt_q, cnt_d;
`endif

    logic [2:0]         win;
    logic               win_vld;
    logic [N_REQ*9-1:0] addr_sh;
    logic [N_REQ*8-1:0] wdata_sh;
    logic [N_REQ-1:0]   write_sh;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_vld)
    );

    assign addr_sh  = req_addr >> (9 * int'(win));
    assign wdata_sh = req_wdata >> (8 * int'(win));
    assign write_sh = req_write >> win;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d  = ST_SETUP;
                    gnt_d    = win;
                    ptr_d    = 3'((int'(win) + 1) % N_REQ);
                    paddr_d  = addr_sh[8:0];
                    pwdata_d = wdata_sh[7:0];
                    pwrite_d = write_sh[0];
                    psel_d   = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    err_d     = PSLVERR;
                    if (!pwrite_q) rdata_d = PRDATA;
                    for (int i = 0; i < N_REQ; i++)
                        if (gnt_q == 3'(i)) done_d[i] = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    // Stuck slave: release the bus and report a failed read
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = 8'hFF;
                    for (int i = 0; i < N_REQ; i++)
                        if (gnt_q == 3'(i)) done_d[i] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign done      = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign gnt_id    = gnt_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Directed bench for i2c_apb_arbiter (N_REQ=2, TIMEOUT_CYC=16).
// Timeout vectors run only when APB_ARB_TIMEOUT_EN is defined.
module tb_i2c_apb_arbiter;
    import i2c_apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic [1:0]  req = '0;
    logic [17:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_write = '0;
    logic [1:0]  done;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [2:0]  gnt_id;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    i2c_apb_arbiter #(.N_REQ(2), .TIMEOUT_CYC(16)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_write(req_write), .done(done), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .gnt_id(gnt_id), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_pen", 32'(PENABLE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'h000);
        chk("rst_pwdata", 32'(PWDATA), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h00);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        PRESETN = 1'b1;
        tick();

        // 1: single zero-wait write from requester 0
        req_addr[8:0]  = REG_ADDR0;
        req_wdata[7:0] = 8'h0B;
        req_write[0]   = 1'b1;
        PREADY         = 1'b1;
        req            = 2'b01;
        tick();
        chk("t1_psel", 32'(PSEL), 32'd1);
        chk("t1_pen0", 32'(PENABLE), 32'd0);
        chk("t1_paddr", 32'(PADDR), 32'h00C);
        chk("t1_pwdata", 32'(PWDATA), 32'h0B);
        chk("t1_pwrite", 32'(PWRITE), 32'd1);
        chk("t1_gnt", 32'(gnt_id), 32'd0);
        tick();
        chk("t1_pen1", 32'(PENABLE), 32'd1);
        chk("t1_done_early", 32'(done), 32'd0);
        tick();
        chk("t1_done", 32'(done), 32'b01);
        chk("t1_psel_off", 32'(PSEL), 32'd0);
        chk("t1_rdata_keep", 32'(rsp_rdata), 32'h00);
        req = 2'b00;
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(PSEL), 32'd0);
        chk("t1_paddr_hold", 32'(PADDR), 32'h00C);

        // 2: read STAT from requester 1 with 4 wait states
        req_addr[17:9] = REG_STAT;
        req_write[1]   = 1'b0;
        PREADY         = 1'b0;
        req            = 2'b10;
        tick();
        chk("t2_psel", 32'(PSEL), 32'd1);
        chk("t2_gnt", 32'(gnt_id), 32'd1);
        chk("t2_paddr", 32'(PADDR), 32'h004);
        chk("t2_pwrite", 32'(PWRITE), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_wait_bus",
                32'({PSEL, PENABLE, PWRITE, PADDR}),
                32'({1'b1, 1'b1, 1'b0, 9'h004}));
            chk("t2_wait_done", 32'(done), 32'd0);
            tick();
        end
        PREADY = 1'b1;
        PRDATA = 8'h60;
        tick();
        chk("t2_done", 32'(done), 32'b10);
        chk("t2_rdata", 32'(rsp_rdata), 32'h60);
        chk("t2_err", 32'(rsp_err), 32'd0);
        req    = 2'b00;
        PRDATA = 8'h00;
        tick();

        // 3: both requesting continuously -> 0,1,0,1 every 3 cycles
        req_addr       = {REG_CTRL, REG_SMB};
        req_wdata      = 16'hA55A;
        req_write      = 2'b11;
        req            = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("t3_psel", 32'(PSEL), 32'd1);
            chk("t3_gnt", 32'(gnt_id), 32'(t % 2));
            tick();
            chk("t3_pen", 32'(PENABLE), 32'd1);
            tick();
            chk("t3_done", 32'(done), 32'(1 << (t % 2)));
            if (t == 3) req = 2'b00;
        end
        tick();
        chk("t3_idle", 32'(PSEL), 32'd0);

        // 4: slave error on a DATA write; addr change after grant ignored
        req_addr[8:0]  = REG_DATA;
        req_wdata[7:0] = 8'h33;
        req_write[0]   = 1'b1;
        req            = 2'b01;
        tick();
        chk("t4_gnt", 32'(gnt_id), 32'd0);
        req_addr[8:0] = REG_ADDR1;
        tick();
        chk("t4_paddr_hold", 32'(PADDR), 32'h008);
        PSLVERR = 1'b1;
        tick();
        chk("t4_done", 32'(done), 32'b01);
        chk("t4_err", 32'(rsp_err), 32'd1);
        req     = 2'b00;
        PSLVERR = 1'b0;
        req_addr[17:9] = REG_CTRL;
        req_write[1]   = 1'b0;
        PRDATA         = 8'h5A;
        req            = 2'b10;
        tick();
        chk("t4b_gnt", 32'(gnt_id), 32'd1);
        tick();
        tick();
        chk("t4b_done", 32'(done), 32'b10);
        chk("t4b_err", 32'(rsp_err), 32'd0);
        chk("t4b_rdata", 32'(rsp_rdata), 32'h5A);
        req = 2'b00;
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // 5: stuck slave -> forced termination after 16 ACCESS cycles
        PREADY       = 1'b0;
        req_write[0] = 1'b0;
        req          = 2'b01;
        tick();
        tick();
        chk("t5_pen", 32'(PENABLE), 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk("t5_wait", 32'(done), 32'd0);
            tick();
        end
        tick();
        chk("t5_done", 32'(done), 32'b01);
        chk("t5_err", 32'(rsp_err), 32'd1);
        chk("t5_rdata", 32'(rsp_rdata), 32'hFF);
        chk("t5_psel", 32'(PSEL), 32'd0);
        req = 2'b00;
        tick();
`endif

        // 6: async reset during ACCESS, pending req restarts afterwards
        PREADY         = 1'b0;
        req_addr[17:9] = REG_ADDR0;
        req_write[1]   = 1'b1;
        req            = 2'b10;
        tick();
        tick();
        chk("t6_pen", 32'(PENABLE), 32'd1);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("t6_psel_rst", 32'(PSEL), 32'd0);
        chk("t6_pen_rst", 32'(PENABLE), 32'd0);
        tick();
        chk("t6_done_rst", 32'(done), 32'd0);
        PRESETN = 1'b1;
        PREADY  = 1'b1;
        tick();
        chk("t6_restart", 32'(PSEL), 32'd1);
        chk("t6_gnt", 32'(gnt_id), 32'd1);
        tick();
        tick();
        chk("t6_done", 32'(done), 32'b10);
        req = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
